// File: rtl/timer_counter_pkg.sv
// Shared definitions for the memory-mapped countdown timer: register map,
// CTRL field positions, FSM state encoding and CTRL pack/unpack helpers.
package timer_counter_pkg;

   // Word addresses inside the device window
   localparam logic [1:0] AddrCtrl   = 2'd0;
   localparam logic [1:0] AddrPreset = 2'd1;
   localparam logic [1:0] AddrCount  = 2'd2;

   // CTRL bit positions
   localparam int unsigned CtrlEnBit   = 0;
   localparam int unsigned CtrlModeLsb = 1;
   localparam int unsigned CtrlModeMsb = 2;
   localparam int unsigned CtrlImBit   = 3;

   // Only mode 1 reloads; every other mode value behaves as one-shot
   localparam logic [1:0] ModeReload = 2'd1;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StLoad = 2'd1,
      StCnt  = 2'd2,
      StInt  = 2'd3
   } tc_state_e;

   // Implemented CTRL fields; bits [31:4] do not exist in hardware
   typedef struct packed {
      logic       im;
      logic [1:0] mode;
      logic       en;
   } tc_ctrl_t;

   function automatic tc_ctrl_t word_to_ctrl(logic [31:0] w);
      tc_ctrl_t c;
      c.en   = w[CtrlEnBit];
      c.mode = w[CtrlModeMsb:CtrlModeLsb];
      c.im   = w[CtrlImBit];
      return c;
   endfunction

   function automatic logic [31:0] ctrl_to_word(tc_ctrl_t c);
      logic [31:0] w;
      w                          = '0;
      w[CtrlEnBit]               = c.en;
      w[CtrlModeMsb:CtrlModeLsb] = c.mode;
      w[CtrlImBit]               = c.im;
      return w;
   endfunction

endpackage

// File: rtl/timer_counter_if.sv
// Device-bus responder interface between the system bridge and the timer.
// Signal names follow the bridge side of the bus.
interface timer_counter_if;

   logic [3:2]  Addr;
   logic        WE;
   logic [31:0] DIN;
   logic [31:0] DOUT;

   // Bridge side drives address/strobe/data and samples read data
   modport master (
      output Addr,
      output WE,
      output DIN,
      input  DOUT
   );

   // Timer side
   modport slave (
      input  Addr,
      input  WE,
      input  DIN,
      output DOUT
   );

endinterface

// File: rtl/timer_counter.sv
// Memory-mapped countdown timer. CTRL/PRESET are bus writable, COUNT is
// read-only. One-shot mode holds IRQ until CTRL is rewritten; auto-reload
// mode emits a one-cycle IRQ pulse each period and restarts by itself.
module timer_counter
   import timer_counter_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   timer_counter_if.slave bus,
   output logic           IRQ
);

   tc_state_e   state_q, state_d;
   tc_ctrl_t    ctrl_q, ctrl_d;
   logic [31:0] preset_q, preset_d;
   logic [31:0] count_q, count_d;
   logic        held_q, held_d;

   logic wr_ctrl;
   logic wr_preset;

   assign wr_ctrl   = bus.WE & (bus.Addr == AddrCtrl);
   assign wr_preset = bus.WE & (bus.Addr == AddrPreset);

   // FSM next state and register updates; bus writes are applied last so they win
   always_comb begin
      state_d  = state_q;
      ctrl_d   = ctrl_q;
      preset_d = preset_q;
      count_d  = count_q;
      held_d   = held_q;

      unique case (state_q)
         StIdle: begin
            if (ctrl_q.en) begin
               state_d = StLoad;
            end
         end
         StLoad: begin
            count_d = preset_q;
            state_d = StCnt;
         end
         StCnt: begin
            // Decrement is suppressed at zero, so COUNT never wraps
            if (!ctrl_q.en) begin
               state_d = StIdle;
            end else if (count_q != 32'd0) begin
               count_d = count_q - 32'd1;
            end else begin
               state_d = StInt;
            end
         end
         StInt: begin
            state_d = StIdle;
            // One-shot stops itself and latches the interrupt; reload keeps Enable set
            if (ctrl_q.mode != ModeReload) begin
               ctrl_d.en = 1'b0;
               held_d    = 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (wr_ctrl) begin
         ctrl_d = word_to_ctrl(bus.DIN);
         held_d = 1'b0;
      end
      if (wr_preset) begin
         preset_d = bus.DIN;
      end
   end

   // State and register file, cleared asynchronously
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= StIdle;
         ctrl_q   <= '0;
         preset_q <= '0;
         count_q  <= '0;
         held_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ctrl_q   <= ctrl_d;
         preset_q <= preset_d;
         count_q  <= count_d;
         held_q   <= held_d;
      end
   end

   // Combinational read mux; returns the pre-edge register value
   always_comb begin
      bus.DOUT = '0;
      unique case (bus.Addr)
         AddrCtrl:   bus.DOUT = ctrl_to_word(ctrl_q);
         AddrPreset: bus.DOUT = preset_q;
         AddrCount:  bus.DOUT = count_q;
         default:    bus.DOUT = '0;
      endcase
   end

   // Interrupt: pulse while in INT, or held after a one-shot expiry; IM gates both
   always_comb begin
      IRQ = ctrl_q.im & ((state_q == StInt) | held_q);
   end

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: a behavioural model tracks the
// register map and timer phase, a per-cycle monitor compares DOUT/IRQ
// against it, and directed scenarios pin literal expectations.
module tb_timer_counter;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic irq;

   timer_counter_if tc_if ();

   timer_counter u_dut (
      .clk  (clk),
      .reset(reset),
      .bus  (tc_if),
      .IRQ  (irq)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Behavioural model: phase 0 idle, 1 load, 2 counting, 3 expired
   logic        m_en     = 1'b0;
   logic [1:0]  m_mode   = 2'd0;
   logic        m_im     = 1'b0;
   logic [31:0] m_preset = '0;
   logic [31:0] m_count  = '0;
   logic        m_held   = 1'b0;
   int          m_phase  = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, got, exp);
      end
   endtask

   task automatic model_clear();
      m_en = 1'b0; m_mode = 2'd0; m_im = 1'b0; m_preset = '0;
      m_count = '0; m_held = 1'b0; m_phase = 0;
   endtask

   task automatic model_step();
      int          ph;
      logic        en;
      logic [31:0] cnt;
      logic        held;
      ph = m_phase; en = m_en; cnt = m_count; held = m_held;
      case (m_phase)
         0: if (m_en) ph = 1;
         1: begin cnt = m_preset; ph = 2; end
         2: begin
            if (!m_en) ph = 0;
            else if (m_count != 0) cnt = m_count - 1;
            else ph = 3;
         end
         default: begin
            ph = 0;
            if (m_mode != 2'd1) begin en = 1'b0; held = 1'b1; end
         end
      endcase
      if (tc_if.WE && tc_if.Addr == 2'd0) begin
         en = tc_if.DIN[0]; m_mode = tc_if.DIN[2:1]; m_im = tc_if.DIN[3]; held = 1'b0;
      end
      if (tc_if.WE && tc_if.Addr == 2'd1) m_preset = tc_if.DIN;
      m_phase = ph; m_en = en; m_count = cnt; m_held = held;
   endtask

   function automatic logic [31:0] exp_dout(input logic [1:0] a);
      case (a)
         2'd0:    return {28'd0, m_im, m_mode, m_en};
         2'd1:    return m_preset;
         2'd2:    return m_count;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic exp_irq();
      return m_im & ((m_phase == 3) | m_held);
   endfunction

   // Inputs change 1ns after a rising edge; every call returns at that point
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      tc_if.Addr = a;
      tc_if.WE   = 1'b1;
      tc_if.DIN  = d;
      @(posedge clk);
      #1;
      tc_if.WE  = 1'b0;
      tc_if.DIN = '0;
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
      tc_if.Addr = a;
      #1;
      check(name, tc_if.DOUT, exp);
   endtask

   initial begin
      tc_if.Addr = '0;
      tc_if.WE   = 1'b0;
      tc_if.DIN  = '0;

      fork
         forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_clear();
            else model_step();
         end
         forever begin
            @(negedge clk);
            check("model_dout", tc_if.DOUT, exp_dout(tc_if.Addr));
            check("model_irq", {31'd0, irq}, {31'd0, exp_irq()});
         end
      join_none

      #1 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      // Reset state
      rd(2'd0, 32'd0, "reset_ctrl");
      rd(2'd1, 32'd0, "reset_preset");
      rd(2'd2, 32'd0, "reset_count");
      check("reset_irq", {31'd0, irq}, 32'd0);

      // One-shot, PRESET=5: COUNT 5..0 from E2, IRQ from E8, held until CTRL write
      bus_write(2'd1, 32'd5);
      bus_write(2'd0, 32'h9);
      idle(2);
      rd(2'd2, 32'd5, "os_count_e2");
      for (int k = 4; k >= 0; k--) begin
         idle(1);
         rd(2'd2, k, "os_count_dec");
      end
      check("os_irq_e7", {31'd0, irq}, 32'd0);
      idle(1);
      check("os_irq_e8", {31'd0, irq}, 32'd1);
      rd(2'd0, 32'h9, "os_ctrl_e8");
      for (int k = 0; k < 20; k++) begin
         idle(1);
         check("os_irq_held", {31'd0, irq}, 32'd1);
      end
      rd(2'd0, 32'h8, "os_ctrl_after");
      bus_write(2'd0, 32'h0);
      check("os_irq_cleared", {31'd0, irq}, 32'd0);

      // Auto-reload, PRESET=3: single-cycle pulses after E6, E13, E20
      bus_write(2'd1, 32'd3);
      bus_write(2'd0, 32'hB);
      for (int c = 1; c <= 22; c++) begin
         idle(1);
         check("ar_pulse", {31'd0, irq}, (c == 6 || c == 13 || c == 20) ? 32'd1 : 32'd0);
      end
      rd(2'd0, 32'hB, "ar_ctrl");
      bus_write(2'd0, 32'h0);
      idle(2);

      // Stop mid-count: CTRL=0 written at E62 leaves COUNT at 40
      bus_write(2'd1, 32'd100);
      bus_write(2'd0, 32'h9);
      idle(61);
      bus_write(2'd0, 32'h0);
      idle(1);
      rd(2'd2, 32'd40, "stop_count");
      for (int k = 0; k < 10; k++) begin
         idle(1);
         rd(2'd2, 32'd40, "stop_hold");
         check("stop_irq", {31'd0, irq}, 32'd0);
      end
      bus_write(2'd1, 32'd2);
      bus_write(2'd0, 32'h9);
      idle(2);
      rd(2'd2, 32'd2, "reload_count");
      idle(2);
      check("reload_irq_e4", {31'd0, irq}, 32'd0);
      idle(1);
      check("reload_irq_e5", {31'd0, irq}, 32'd1);

      // COUNT is read-only; CTRL upper bits are not stored
      bus_write(2'd0, 32'h0);
      bus_write(2'd1, 32'd50);
      bus_write(2'd0, 32'h9);
      idle(5);
      bus_write(2'd2, 32'h1234);
      rd(2'd2, 32'd46, "count_ro");
      bus_write(2'd0, 32'hFFFF_FFF1);
      rd(2'd0, 32'h1, "ctrl_mask");
      rd(2'd2, 32'd45, "count_after_ctrl");

      // Asynchronous reset while IRQ is held
      bus_write(2'd0, 32'h0);
      bus_write(2'd1, 32'd4);
      bus_write(2'd0, 32'h9);
      idle(10);
      check("pre_reset_irq", {31'd0, irq}, 32'd1);
      #2 reset = 1'b0;
      #1;
      check("async_irq", {31'd0, irq}, 32'd0);
      rd(2'd0, 32'd0, "async_ctrl");
      rd(2'd1, 32'd0, "async_preset");
      rd(2'd2, 32'd0, "async_count");
      @(posedge clk);
      #1 reset = 1'b1;
      idle(1);

      // PRESET=0: LOAD, CNT, INT with no decrement
      bus_write(2'd0, 32'h9);
      idle(2);
      rd(2'd2, 32'd0, "p0_count");
      check("p0_irq_e2", {31'd0, irq}, 32'd0);
      idle(1);
      check("p0_irq_e3", {31'd0, irq}, 32'd1);

      // Mode 2 behaves as one-shot
      bus_write(2'd0, 32'h0);
      bus_write(2'd1, 32'd1);
      bus_write(2'd0, 32'hD);
      idle(5);
      rd(2'd0, 32'hC, "m2_ctrl");
      check("m2_irq", {31'd0, irq}, 32'd1);

      idle(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
